// File: rtl/sorting_ctrl_if.sv
// ---------------------------------------------------------------------------
// sorting_ctrl_if
//
// Record-stream bundle for the sorting-cell batch controller. It carries two
// valid/ready streams:
//   in_*  : unsorted records into the controller (in_last marks batch end)
//   out_* : sorted records out of the controller (out_last marks batch end)
//
// Modports
//   master : the environment side (record source + sorted-record consumer)
//   slave  : the controller side (sorting_ctrl)
//
// Records are 32 bits: priority key [19:12], tiebreak [11:0].
// ---------------------------------------------------------------------------
interface sorting_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sorting_ctrl.sv
// ---------------------------------------------------------------------------
// sorting_ctrl
//
// Batch controller for a systolic chain of DEPTH sorting cells. Records
// arrive one per cycle on rec.in_*, are broadcast to the chain through
// cell_en / cell_new_data, and on the batch's last record (or when the chain
// is full) the sorted contents are read back head-first on rec.out_*. The
// chain is then cleared with a one-cycle cell_clear pulse before the next
// batch is accepted.
//
// Parameters
//   DEPTH  number of sorting cells (2..64), also the maximum batch size
//   IDX_W  width of the entry counter and read index
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   rec             sorting_ctrl_if.slave: input and output record streams
//   cell_en         insertion strobe to every cell
//   cell_new_data   record broadcast to every cell (0 outside LOAD)
//   cell_clear      registered clear pulse, ORed into the array reset
//   cell_data_bus   concatenated cell data, cell 0 (head) in the low word
//   cell_state_vec  concatenated cell occupancy bits
//   busy            high while settling, draining or clearing
//   trunc           sticky: batch reached DEPTH without in_last
//   err             sticky occupancy mismatch (checker build only)
//
// Build option
//   SORT_CTRL_CHECK_EN  when defined, occupancy is cross-checked against the
//                       entry count in SETTLE and against an empty chain in
//                       the cycle after CLEAR; otherwise err is tied to 0.
// ---------------------------------------------------------------------------
module sorting_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  sorting_ctrl_if.slave         rec,
  output logic                  cell_en,
  output logic [31:0]           cell_new_data,
  output logic                  cell_clear,
  input  logic [DEPTH*32-1:0]   cell_data_bus,
  input  logic [DEPTH-1:0]      cell_state_vec,
  output logic                  busy,
  output logic                  trunc,
  output logic                  err
);

  localparam int                DATA_W    = 32;
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  ONE       = IDX_W'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SETTLE,
    S_DRAIN,
    S_CLEAR
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   count;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   rd_nxt;
  logic [IDX_W-1:0]   cnt_m1;
  logic               accept;
  logic               out_hs;

  // Mux one cell word out of the concatenated bus; loop form keeps the
  // index width independent of DEPTH.
  function automatic logic [DATA_W-1:0] cell_sel(
    input logic [DEPTH*DATA_W-1:0] bus,
    input logic [IDX_W-1:0]        idx
  );
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == IDX_W'(i)) res = bus[DATA_W*i +: DATA_W];
    end
    return res;
  endfunction

  assign rd_nxt = rd_idx + ONE;
  assign cnt_m1 = count - ONE;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // Next-state and combinational outputs
  always_comb begin
    state_nxt     = state;
    rec.in_ready  = 1'b0;
    cell_en       = 1'b0;
    cell_new_data = '0;
    busy          = 1'b0;
    accept        = 1'b0;
    out_hs        = 1'b0;
    unique case (state)
      S_LOAD: begin
        // in_ready is withheld while rst is asserted so nothing is taken
        // during reset.
        rec.in_ready  = !rst;
        accept        = rec.in_valid & !rst;
        cell_en       = accept;
        cell_new_data = rec.in_data;
        if (accept && (rec.in_last || count == LAST_SLOT)) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy      = 1'b1;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        out_hs = rec.out_valid & rec.out_ready;
        if (out_hs && rec.out_last) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        state_nxt = S_LOAD;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Counters, output register and clear pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      rd_idx        <= '0;
      rec.out_valid <= 1'b0;
      rec.out_last  <= 1'b0;
      rec.out_data  <= '0;
      cell_clear    <= 1'b0;
      trunc         <= 1'b0;
    end else begin
      cell_clear <= (state_nxt == S_CLEAR);
      unique case (state)
        S_LOAD: begin
          if (accept) begin
            count <= count + ONE;
            // DEPTH >= 2, so the first slot and the last slot never coincide.
            if (count == '0) trunc <= 1'b0;
            if (count == LAST_SLOT && !rec.in_last) trunc <= 1'b1;
          end
        end
        S_SETTLE: begin
          rec.out_data  <= cell_sel(cell_data_bus, '0);
          rd_idx        <= '0;
          rec.out_valid <= 1'b1;
          rec.out_last  <= (count == ONE);
        end
        S_DRAIN: begin
          if (out_hs) begin
            if (rec.out_last) begin
              rec.out_valid <= 1'b0;
              rec.out_last  <= 1'b0;
            end else if (rd_idx < cnt_m1) begin
              rd_idx       <= rd_nxt;
              rec.out_data <= cell_sel(cell_data_bus, rd_nxt);
              rec.out_last <= (rd_nxt == cnt_m1);
            end
          end
        end
        S_CLEAR: begin
          count <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_CTRL_CHECK_EN
  logic             post_clear;
  logic             chk_set;
  logic [IDX_W-1:0] occ;

  function automatic logic [IDX_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [IDX_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + IDX_W'(v[i]);
    return c;
  endfunction

  assign occ = popcount(cell_state_vec);

  // Occupancy must equal the entry count once the chain has settled, and the
  // chain must read empty in the first cycle after the clear pulse.
  always_comb begin
    chk_set = 1'b0;
    if (state == S_SETTLE && occ != count) chk_set = 1'b1;
    if (post_clear && |cell_state_vec)     chk_set = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_clear <= 1'b0;
      err        <= 1'b0;
    end else begin
      post_clear <= (state == S_CLEAR);
      // A detected fault wins over the first-accept clear in the same cycle.
      if (chk_set)                    err <= 1'b1;
      else if (accept && count == '0) err <= 1'b0;
    end
  end
`else
  logic unused_state;
  assign unused_state = ^cell_state_vec;
  assign err          = 1'b0;
`endif

endmodule
